// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_REQ requesters.
// Launches one frame at a time and flags a transmitter that never raises busy.
module tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     dados,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           fim,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       erro,
    output logic                       tx_send,
    output logic [WIDTH-1:0]           tx_palavra,
    input  logic                       tx_busy
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   winner;
    logic            found;
    logic [GW-1:0]   idx;

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = GW'((32'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            ack        <= '0;
            fim        <= '0;
            grant_id   <= '0;
            erro       <= 1'b0;
            tx_send    <= 1'b0;
            tx_palavra <= '0;
        end else begin
            ack     <= '0;
            fim     <= '0;
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id    <= winner;
                        tx_palavra  <= dados[winner*WIDTH +: WIDTH];
                        ack[winner] <= 1'b1;
                        tx_send     <= 1'b1;
                        ptr         <= GW'((32'(winner) + 1) % N_REQ);
                        cnt         <= '0;
                        state       <= SEND;
                    end
                end
                SEND: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        erro  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        fim[grant_id] <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
